// File: rtl/neuro_result_voter_pkg.sv
// Shared types and width helpers for the temporal classifier-result voter.
package neuro_pkg;

    localparam int DEFAULT_NUM_CLASSES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_SCAN   = 2'd2,
        ST_EMIT   = 2'd3
    } voter_state_e;

    function automatic int class_w(input int num_classes);
        return (num_classes > 2) ? $clog2(num_classes) : 1;
    endfunction

    function automatic int count_w(input int window);
        return $clog2(window + 1);
    endfunction

    function automatic int ptr_w(input int window);
        return (window > 1) ? $clog2(window) : 1;
    endfunction

endpackage

// File: rtl/neuro_result_voter_if.sv
// Signal bundle between the classifier core (master) and the result voter (slave).
interface neuro_result_voter_if
    import neuro_pkg::*;
#(
    parameter int CLASS_W = 2,
    parameter int CONF_W  = 2,
    parameter int CNT_W   = 32
);
    // stop is a one-cycle strobe qualifying result; there is no backpressure, so a stop that
    // cannot be held is dropped and flagged on overrun. vote_valid is a one-cycle strobe
    // qualifying vote_result/vote_conf, which otherwise hold their last value.
    logic               go;
    logic               stop;
    logic [CLASS_W-1:0] result;
    logic               clear;
    logic [CLASS_W-1:0] vote_result;
    logic [CONF_W-1:0]  vote_conf;
    logic               vote_valid;
    logic [CONF_W-1:0]  fill;
    logic               busy;
    logic               overrun;
    logic [CNT_W-1:0]   last_cycles;
    voter_state_e       state_dbg;

    modport master (
        output go, stop, result, clear,
        input  vote_result, vote_conf, vote_valid, fill, busy, overrun, last_cycles, state_dbg
    );

    modport slave (
        input  go, stop, result, clear,
        output vote_result, vote_conf, vote_valid, fill, busy, overrun, last_cycles, state_dbg
    );

endinterface

// File: rtl/neuro_result_voter_argmax_scan.sv
// Sequential arg-max: one candidate per enabled cycle, strict-greater replacement,
// and a tie-keep input that lets a caller hold its previous winner on equal counts.
module argmax_scan #(
    parameter int IDX_W = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    input  logic [IDX_W-1:0] cand_idx,
    input  logic [CNT_W-1:0] cand_cnt,
    input  logic [IDX_W-1:0] keep_idx,
    input  logic [CNT_W-1:0] keep_cnt,
    output logic [IDX_W-1:0] win_idx,
    output logic [CNT_W-1:0] win_cnt
);

    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;

    always_comb begin
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
        if (start) begin
            best_idx_d = '0;
            best_cnt_d = '0;
        end else if (en && (cand_cnt > best_cnt_q)) begin
            best_idx_d = cand_idx;
            best_cnt_d = cand_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_idx_q <= '0;
            best_cnt_q <= '0;
        end else begin
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
        end
    end

    assign win_idx = (keep_cnt == best_cnt_q) ? keep_idx : best_idx_q;
    assign win_cnt = best_cnt_q;

endmodule

// File: rtl/neuro_result_voter.sv
// Sliding-window majority voter over classifier results, with one-deep stop buffering,
// overrun flag and a saturating go-to-stop cycle counter.
module neuro_result_voter
    import neuro_pkg::*;
#(
    parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
    parameter int CLASS_W     = class_w(NUM_CLASSES),
    parameter int WINDOW      = 3,
    parameter bit EARLY_VOTE  = 1'b0,
    parameter int CNT_W       = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    neuro_result_voter_if.slave bus
);

    localparam int CONF_W = count_w(WINDOW);
    localparam int PTR_W  = ptr_w(WINDOW);
    localparam logic [CONF_W-1:0]  FILL_MAX = CONF_W'(WINDOW);
    localparam logic [PTR_W-1:0]   PTR_MAX  = PTR_W'(WINDOW - 1);
    localparam logic [CLASS_W-1:0] IDX_MAX  = CLASS_W'(NUM_CLASSES - 1);

    voter_state_e       state_q, state_d;
    logic [CLASS_W-1:0] hist_q [WINDOW];
    logic [CLASS_W-1:0] hist_d [WINDOW];
    logic [CONF_W-1:0]  count_q [NUM_CLASSES];
    logic [CONF_W-1:0]  count_d [NUM_CLASSES];
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CONF_W-1:0]  fill_q, fill_d;
    logic [CLASS_W-1:0] upd_res_q, upd_res_d;
    logic [CLASS_W-1:0] scan_idx_q, scan_idx_d;
    logic [CLASS_W-1:0] pend_res_q, pend_res_d;
    logic [CLASS_W-1:0] vote_result_q, vote_result_d;
    logic [CONF_W-1:0]  vote_conf_q, vote_conf_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic               vote_valid_q, vote_valid_d;
    logic               go_q, go_d, meas_q, meas_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d, last_q, last_d, cyc_inc;

    logic               stop_eff, full, can_start, take_pending, scan_start, scan_en;
    logic [CLASS_W-1:0] evict, win_idx;
    logic [CONF_W-1:0]  win_cnt;

    assign stop_eff     = bus.stop & ~bus.clear;
    assign full         = (fill_q == FILL_MAX);
    assign evict        = hist_q[ptr_q];
    // Only IDLE and EMIT may launch an update; EMIT chains straight into a buffered stop.
    assign can_start    = (state_q == ST_IDLE) || (state_q == ST_EMIT);
    assign take_pending = can_start && pending_q;

    argmax_scan #(.IDX_W(CLASS_W), .CNT_W(CONF_W)) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (scan_start),
        .en       (scan_en),
        .cand_idx (scan_idx_q),
        .cand_cnt (count_q[scan_idx_q]),
        .keep_idx (vote_result_q),
        .keep_cnt (count_q[vote_result_q]),
        .win_idx  (win_idx),
        .win_cnt  (win_cnt)
    );

    always_comb begin
        state_d       = state_q;
        hist_d        = hist_q;
        count_d       = count_q;
        ptr_d         = ptr_q;
        fill_d        = fill_q;
        upd_res_d     = upd_res_q;
        scan_idx_d    = scan_idx_q;
        pend_res_d    = pend_res_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        vote_result_d = vote_result_q;
        vote_conf_d   = vote_conf_q;
        vote_valid_d  = 1'b0;
        scan_start    = 1'b0;
        scan_en       = 1'b0;

        if (take_pending) pending_d = 1'b0;
        if (stop_eff && !(can_start && !pending_q)) begin
            if (pending_q && !can_start) begin
                overrun_d = 1'b1;
            end else begin
                pending_d  = 1'b1;
                pend_res_d = bus.result;
            end
        end

        case (state_q)
            ST_UPDATE: begin
                // An incoming class equal to the evicted one leaves every count unchanged.
                if (!(full && (evict == upd_res_q))) begin
                    count_d[upd_res_q] = count_q[upd_res_q] + CONF_W'(1);
                    if (full) count_d[evict] = count_q[evict] - CONF_W'(1);
                end
                hist_d[ptr_q] = upd_res_q;
                ptr_d         = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
                if (!full) fill_d = fill_q + CONF_W'(1);
                scan_idx_d = '0;
                scan_start = 1'b1;
                state_d    = ST_SCAN;
            end
            ST_SCAN: begin
                scan_en = 1'b1;
                if (scan_idx_q == IDX_MAX) state_d = ST_EMIT;
                else                       scan_idx_d = scan_idx_q + CLASS_W'(1);
            end
            ST_EMIT: begin
                if (EARLY_VOTE || full) begin
                    vote_result_d = win_idx;
                    vote_conf_d   = win_cnt;
                    vote_valid_d  = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
            end
        endcase

        if (take_pending) begin
            state_d   = ST_UPDATE;
            upd_res_d = pend_res_q;
        end else if (can_start && stop_eff) begin
            state_d   = ST_UPDATE;
            upd_res_d = bus.result;
        end

        if (bus.clear) begin
            state_d      = ST_IDLE;
            ptr_d        = '0;
            fill_d       = '0;
            count_d      = '{default: '0};
            pending_d    = 1'b0;
            overrun_d    = 1'b0;
            vote_valid_d = 1'b0;
        end
    end

    always_comb begin
        go_d    = bus.go;
        meas_d  = meas_q;
        cyc_d   = cyc_q;
        last_d  = last_q;
        cyc_inc = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
        // The stop cycle itself is counted, so a 1-cycle go then stop reports 1.
        if (meas_q) begin
            if (stop_eff) begin
                last_d = cyc_inc;
                meas_d = 1'b0;
            end else begin
                cyc_d = cyc_inc;
            end
        end else if (bus.go && !go_q) begin
            cyc_d  = '0;
            meas_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hist_q        <= '{default: '0};
            count_q       <= '{default: '0};
            ptr_q         <= '0;
            fill_q        <= '0;
            upd_res_q     <= '0;
            scan_idx_q    <= '0;
            pend_res_q    <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            vote_result_q <= '0;
            vote_conf_q   <= '0;
            vote_valid_q  <= 1'b0;
            go_q          <= 1'b0;
            meas_q        <= 1'b0;
            cyc_q         <= '0;
            last_q        <= '0;
        end else begin
            state_q       <= state_d;
            hist_q        <= hist_d;
            count_q       <= count_d;
            ptr_q         <= ptr_d;
            fill_q        <= fill_d;
            upd_res_q     <= upd_res_d;
            scan_idx_q    <= scan_idx_d;
            pend_res_q    <= pend_res_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            vote_result_q <= vote_result_d;
            vote_conf_q   <= vote_conf_d;
            vote_valid_q  <= vote_valid_d;
            go_q          <= go_d;
            meas_q        <= meas_d;
            cyc_q         <= cyc_d;
            last_q        <= last_d;
        end
    end

    assign bus.vote_result = vote_result_q;
    assign bus.vote_conf   = vote_conf_q;
    assign bus.vote_valid  = vote_valid_q;
    assign bus.fill        = fill_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.overrun     = overrun_q;
    assign bus.last_cycles = last_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_neuro_result_voter.sv
// Directed bench: three voter configurations share one stimulus stream; each phase checks one.
module tb_neuro_result_voter;
    import neuro_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [1:0] result = 2'd0;

    always #5 clk = ~clk;

    // a: W=3 majority vote, 8-bit counter; b: W=2 tie-keep; c: W=5 early vote, 32-bit counter
    neuro_result_voter_if #(.CLASS_W(2), .CONF_W(2), .CNT_W(8))  if_a ();
    neuro_result_voter_if #(.CLASS_W(2), .CONF_W(2), .CNT_W(8))  if_b ();
    neuro_result_voter_if #(.CLASS_W(2), .CONF_W(3), .CNT_W(32)) if_c ();

    assign if_a.go = go;  assign if_a.stop = stop;  assign if_a.result = result;  assign if_a.clear = clear;
    assign if_b.go = go;  assign if_b.stop = stop;  assign if_b.result = result;  assign if_b.clear = clear;
    assign if_c.go = go;  assign if_c.stop = stop;  assign if_c.result = result;  assign if_c.clear = clear;

    neuro_result_voter #(.NUM_CLASSES(4), .WINDOW(3), .EARLY_VOTE(1'b0), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    neuro_result_voter #(.NUM_CLASSES(4), .WINDOW(2), .EARLY_VOTE(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));
    neuro_result_voter #(.NUM_CLASSES(4), .WINDOW(5), .EARLY_VOTE(1'b1), .CNT_W(32)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard for instance a: {vote_result, vote_conf} expected at each vote_valid pulse.
    logic [3:0] exp_q[$];
    bit         mon_a_en = 1'b0;
    int         unexp_a  = 0;

    always @(negedge clk) begin
        if (mon_a_en && if_a.vote_valid) begin
            if (exp_q.size() == 0) unexp_a++;
            else check("vote_a", {if_a.vote_result, if_a.vote_conf}, exp_q.pop_front());
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0; go = 1'b0; stop = 1'b0; clear = 1'b0; result = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic sel_valid(input int which);
        case (which)
            0:       return if_a.vote_valid;
            1:       return if_b.vote_valid;
            default: return if_c.vote_valid;
        endcase
    endfunction

    // One-cycle stop, then a bounded 10-cycle watch recording when/how often vote_valid pulses.
    task automatic send_stop(input logic [1:0] r, input int which, output int lat, output int pulses);
        lat = 0;
        pulses = 0;
        @(negedge clk); stop = 1'b1; result = r;
        @(negedge clk); stop = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            if (sel_valid(which)) begin
                pulses++;
                if (lat == 0) lat = k;
            end
        end
    endtask

    // go high for n cycles, then stop in the cycle go drops.
    task automatic measure(input int n);
        @(negedge clk); go = 1'b1;
        repeat (n) @(negedge clk);
        go = 1'b0; stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    initial begin
        int lat, pulses, busy_cnt;
        int hist[$];
        int cnt[4];
        int mx;
        logic [1:0] m_vote;
        bit found;
        logic [1:0] seq6 [7];
        seq6 = '{2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd2};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_vote_result", if_a.vote_result, 0);
        check("rst_vote_conf",   if_a.vote_conf, 0);
        check("rst_vote_valid",  if_a.vote_valid, 0);
        check("rst_fill",        if_a.fill, 0);
        check("rst_busy",        if_a.busy, 0);
        check("rst_overrun",     if_a.overrun, 0);
        check("rst_last_cycles", if_a.last_cycles, 0);
        check("rst_state",       if_a.state_dbg, ST_IDLE);

        // Majority forms: 2,1,2 -> one vote (2, conf 2) after the third, latency 7 negedges
        mon_a_en = 1'b1;
        send_stop(2'd2, 0, lat, pulses);
        check("p1_fill1", if_a.fill, 1);
        check("p1_pulses1", pulses, 0);
        send_stop(2'd1, 0, lat, pulses);
        check("p1_fill2", if_a.fill, 2);
        check("p1_pulses2", pulses, 0);
        exp_q.push_back({2'd2, 2'd2});
        send_stop(2'd2, 0, lat, pulses);
        check("p1_latency", lat, 7);
        check("p1_pulses3", pulses, 1);
        check("p1_fill3", if_a.fill, 3);
        check("p1_vote_hold", if_a.vote_result, 2);

        // Window 1,2,1 -> vote 1 conf 2; second 1 evicts a 1, counts unchanged
        exp_q.push_back({2'd1, 2'd2});
        send_stop(2'd1, 0, lat, pulses);
        check("p2_pulses1", pulses, 1);
        exp_q.push_back({2'd1, 2'd2});
        send_stop(2'd1, 0, lat, pulses);
        check("p2_pulses2", pulses, 1);
        check("p2_fill", if_a.fill, 3);

        // Clear keeps the vote; then three back-to-back stops: 2 processed, 1 dropped
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("p3_clr_fill", if_a.fill, 0);
        check("p3_clr_vote", if_a.vote_result, 1);
        check("p3_clr_conf", if_a.vote_conf, 2);
        check("p3_clr_overrun", if_a.overrun, 0);
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k > 0 && if_a.busy) busy_cnt++;
            case (k)
                0:       begin stop = 1'b1; result = 2'd3; end
                1:       result = 2'd3;
                2:       result = 2'd0;
                3:       stop = 1'b0;
                default: begin end
            endcase
        end
        check("p3_busy_cycles", busy_cnt, 12);
        check("p3_overrun", if_a.overrun, 1);
        check("p3_fill", if_a.fill, 2);

        // clear together with stop mid-SCAN aborts the vote that would have filled the window
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            case (k)
                0: begin stop = 1'b1; result = 2'd0; end
                1: stop = 1'b0;
                3: begin
                    check("p5_mid_scan", if_a.state_dbg, ST_SCAN);
                    clear = 1'b1; stop = 1'b1; result = 2'd2;
                end
                4: begin
                    clear = 1'b0; stop = 1'b0;
                    check("p5_state_idle", if_a.state_dbg, ST_IDLE);
                    check("p5_busy", if_a.busy, 0);
                    check("p5_fill", if_a.fill, 0);
                    check("p5_overrun", if_a.overrun, 0);
                    check("p5_vote_kept", if_a.vote_result, 1);
                    check("p5_conf_kept", if_a.vote_conf, 2);
                end
                default: begin end
            endcase
        end
        check("a_stray_votes", unexp_a, 0);
        check("a_exp_q_drained", exp_q.size(), 0);
        mon_a_en = 1'b0;

        // Tie keeps previous vote, W=2: 3,3 -> (3,2); 0 -> (3,1); 3 -> (3,1)
        do_reset();
        send_stop(2'd3, 1, lat, pulses);
        check("p2b_pulses1", pulses, 0);
        send_stop(2'd3, 1, lat, pulses);
        check("p2b_latency", lat, 7);
        check("p2b_vote1", if_b.vote_result, 3);
        check("p2b_conf1", if_b.vote_conf, 2);
        send_stop(2'd0, 1, lat, pulses);
        check("p2b_pulses3", pulses, 1);
        check("p2b_vote2", if_b.vote_result, 3);
        check("p2b_conf2", if_b.vote_conf, 1);
        send_stop(2'd3, 1, lat, pulses);
        check("p2b_vote3", if_b.vote_result, 3);
        check("p2b_conf3", if_b.vote_conf, 1);
        check("p2b_fill", if_b.fill, 2);

        // Early vote, W=5, 7 stops so the pointer wraps; recount-from-window model
        do_reset();
        m_vote = 2'd0;
        for (int s = 0; s < 7; s++) begin
            hist.push_back(int'(seq6[s]));
            if (hist.size() > 5) void'(hist.pop_front());
            cnt = '{0, 0, 0, 0};
            foreach (hist[j]) cnt[hist[j]]++;
            mx = 0;
            for (int c = 0; c < 4; c++) if (cnt[c] > mx) mx = cnt[c];
            if (cnt[m_vote] != mx) begin
                found = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    if (!found && cnt[c] == mx) begin
                        m_vote = 2'(c);
                        found = 1'b1;
                    end
                end
            end
            send_stop(seq6[s], 2, lat, pulses);
            check("p6_latency", lat, 7);
            check("p6_vote", if_c.vote_result, m_vote);
            check("p6_conf", if_c.vote_conf, mx);
            check("p6_fill", if_c.fill, hist.size());
            if (s == 0) begin
                check("p6_first_vote", if_c.vote_result, 3);
                check("p6_first_conf", if_c.vote_conf, 1);
            end
        end
        check("p6_final_vote", if_c.vote_result, 2);
        check("p6_final_conf", if_c.vote_conf, 3);

        // Cycle counter: 300 saturates at 255 on 8 bits, 10, 1-cycle pulse, stray stop
        do_reset();
        measure(300);
        check("p4_sat_a", if_a.last_cycles, 255);
        check("p4_wide_c", if_c.last_cycles, 300);
        repeat (10) @(negedge clk);
        measure(10);
        check("p4_ten_a", if_a.last_cycles, 10);
        check("p4_ten_c", if_c.last_cycles, 10);
        repeat (10) @(negedge clk);
        measure(1);
        check("p4_one_a", if_a.last_cycles, 1);
        repeat (10) @(negedge clk);
        send_stop(2'd0, 0, lat, pulses);
        check("p4_stray_stop_a", if_a.last_cycles, 1);
        check("p4_stray_stop_c", if_c.last_cycles, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/neuro_result_voter.md
# neuro_result_voter

Parametrised temporal voter for classifier outputs. Sits between the neural-network core (`TOP`) and the display/LED logic. Each completed inference is pushed into a sliding window of depth `WINDOW`, and the block emits the majority class with a confidence count. It generalises the fixed 3-frame, 2-bit vote to any class count and window depth, and adds deterministic tie-breaking, overrun detection and a saturating per-inference cycle counter.

## Interface
Parameters:
- `NUM_CLASSES`, 4 — number of classes; 2..16.
- `CLASS_W`, `$clog2(NUM_CLASSES)` — result width.
- `WINDOW`, 3 — history depth; 1..15.
- `EARLY_VOTE`, 0 — 1: vote from the first entry; 0: vote only once the window is full.
- `CNT_W`, 32 — cycle-counter width.

Ports:
- `clk` in 1 — single clock.
- `rst_n` in 1 — reset, synchronous, active-low.
- `go` in 1 — inference running (level).
- `stop` in 1 — one-cycle pulse marking inference done; `result` is sampled with it.
- `result` in `CLASS_W` — class from the core.
- `clear` in 1 — synchronous flush of history.
- `vote_result` out `CLASS_W` — current voted class.
- `vote_conf` out `$clog2(WINDOW+1)` — count of the winning class in the window.
- `vote_valid` out 1 — one-cycle pulse when the vote has been recomputed.
- `fill` out `$clog2(WINDOW+1)` — entries held, 0..`WINDOW`.
- `busy` out 1 — high when state is not IDLE.
- `overrun` out 1 — sticky; set when a `stop` is dropped.
- `last_cycles` out `CNT_W` — latched go-to-stop duration of the last inference.

## Operation
- **History.** A circular buffer holds `WINDOW` × `CLASS_W` entries, with a write pointer that wraps at `WINDOW-1`. There is one count register per class, each `$clog2(WINDOW+1)` bits wide.
- **FSM states.** IDLE, UPDATE, SCAN, EMIT.
  - IDLE → UPDATE on `stop`, or on a pending flag.
- **UPDATE.** Increments `count[result]`. When `fill == WINDOW`, it also decrements `count` of the evicted entry at the write pointer. A new value equal to the evicted one leaves that count unchanged. Writes the entry, advances the pointer and saturates `fill` at `WINDOW`. Goes to SCAN with idx=0.
- **SCAN.** Runs one class per cycle, idx 0..`NUM_CLASSES-1`, tracking best count and best idx. A class replaces the current best only if its count is strictly greater. Goes to EMIT after the last idx.
- **Tie-break.** If `count[vote_result]` equals the best count, `vote_result` is kept. Otherwise the lowest-index maximum wins.
- **EMIT.**
  - If `EARLY_VOTE == 1` or `fill == WINDOW`: updates `vote_result` and `vote_conf`, and pulses `vote_valid`.
  - Otherwise: no update and no pulse.
  - Then goes to IDLE.
- **Pending stop.** A `stop` arriving while busy sets a one-deep pending flag, storing its result. A further `stop` while pending is set is dropped and sets `overrun`.
- **Cycle counter.**
  - On a rising `go` edge while not measuring: counter cleared, measuring set.
  - While measuring: counts each cycle, saturating at all-ones.
  - On `stop` while measuring: the value is latched into `last_cycles` and measuring is cleared.
  - A `stop` when not measuring leaves `last_cycles` unchanged.
- **`clear`.**
  - Resets: buffer pointer, `fill`, class counts, pending flag, `overrun`; FSM returns to IDLE.
  - Keeps: `vote_result`, `vote_conf` and `last_cycles`.
  - Priority: over a simultaneous `stop`; the `stop` is discarded.

## Timing
- **Reset values.** All outputs are 0 and the FSM is in IDLE. Counts, buffer and pending flag are cleared.
- **Vote latency.** With `stop` sampled at edge E0, `vote_valid` is high in the cycle after edge E0+`NUM_CLASSES`+2. The FSM is busy for `NUM_CLASSES`+2 cycles.
- **Pending stop.** Enters UPDATE on the edge after EMIT with no IDLE cycle in between.
- **`last_cycles`.** Valid the cycle after the `stop` edge.
- **Count of a 1-cycle `go` pulse.** A `go` high for exactly one cycle followed by `stop` on the next cycle yields `last_cycles` = 1.
- **Reset during SCAN.** Aborts the scan with no `vote_valid` pulse.

## Structure
- Package `neuro_pkg`:
  - FSM state enum.
  - `CLASS_W` and count-width helper functions.
  - Default class count: 4.
- Sub-module `argmax_scan`: sequential max search with tie-keep input. It is reused by later multi-head classifiers.
- History buffer: registers, not RAM (depth ≤ 15).

## Test plan
1. **Majority forms.** Reset, `WINDOW`=3, `NUM_CLASSES`=4; stops with results 2, 1, 2 → single `vote_valid` after the third, `vote_result`=2, `vote_conf`=2, `fill`=3.
2. **Tie keeps previous vote.** Then stops with 1, 1 → after the first of these (window 1,2,1) `vote_result`=1, `vote_conf`=2. Sequence 0, 3 with `WINDOW`=2, prior vote 3 → stays 3, `vote_conf`=1.
3. **Overrun.** Three stops on consecutive cycles → two votes processed back-to-back, `overrun`=1, `fill` increases by 2.
4. **Counter saturation.** `CNT_W`=8, `go` high 300 cycles then `stop` → `last_cycles`=255. `go` 10 cycles then `stop` → 10.
5. **Clear with stop.** `clear` asserted together with `stop` mid-SCAN → FSM IDLE next cycle, `fill`=0, no `vote_valid`, `vote_result` retained.
6. **Early vote and wrap.** `EARLY_VOTE`=1, `WINDOW`=5; first stop result 3 → `vote_valid`, `vote_result`=3, `vote_conf`=1. After 7 stops, the pointer has wrapped and the counts match a reference model.
